fifo_wr_arb_ctrl: RTL and testbench
===================================

Name: fifo_wr_arb_ctrl

Overview:
Write-domain controller for the dual-clock FIFO. It arbitrates NUM_REQ write requesters onto the single FIFO write port using round-robin. It owns the write pointer, publishing a binary address to the RAM and a Gray pointer toward the read domain. It derives full, almost-full and fill count from the read pointer after it has been synchronized into w_clk (two-flop, Gray-coded).

Parameters:
ADDR_WIDTH, 4, RAM address bits; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 8, write data width
NUM_REQ, 4, number of requesters (2..8)
AFULL_THRESH, 2, w_afull asserts when free entries <= AFULL_THRESH

Ports:
w_clk  in  1  write-domain clock
w_rstn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot accept, combinational
wq2_rptr  in  ADDR_WIDTH+1  synchronized read pointer, Gray
w_en  out  1  RAM write enable, combinational (= accept)
w_addr  out  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
w_data  out  DATA_WIDTH  data of granted requester
wptr  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-side synchronizer
w_full  out  1  registered full flag
w_afull  out  1  registered almost-full flag
w_count  out  ADDR_WIDTH+1  registered fill level, pessimistic
grant_id  out  $clog2(NUM_REQ)  index of the current grant; valid when w_en=1

Behaviour:
- Reset (async, w_rstn=0): wbin=0, wptr=0, w_full=0, w_afull=0, w_count=0, last_grant=NUM_REQ-1. On the first post-reset arbitration, requester 0 has highest priority.
- Arbitration (combinational): if w_full=0 and any req_valid, grant the first valid index searching from last_grant+1 upward, modulo NUM_REQ.
  - req_ready is one-hot on the granted index, else all zero. req_ready is all zero whenever w_full=1.
  - Requesters must not drop req_valid or change data until ready is seen.
- Accept: w_en = |(req_valid & req_ready). Mux w_data and grant_id from the granted index. Zero-latency: the RAM writes on the same edge.
- On an accept edge: wbin <= wbin+1 (wraps at 2**(ADDR_WIDTH+1)), wptr <= bin2gray(wbin+1), last_grant <= grant_id. With no accept, last_grant holds.
- Next-state values: wbin_next = wbin + w_en; wgray_next = bin2gray(wbin_next); rbin = gray2bin(wq2_rptr).
- Flag registers, updated every edge:
  - w_full <= (wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
  - w_count <= (wbin_next - rbin) mod 2**(ADDR_WIDTH+1); range 0..DEPTH.
  - w_afull <= (wbin_next - rbin) >= DEPTH-AFULL_THRESH.
- Full behaviour: asserts on the edge of the DEPTH-th unread accept, so no accept is ever possible while full.
  - Deasserts one edge after wq2_rptr advances.
  - Flags are pessimistic: a read is reflected only after the synchronizer delay, and never early.
- Wrap-around: pointer MSB toggles every DEPTH writes. Gray output changes exactly one bit per accept, including the 2*DEPTH-1 -> 0 wrap.
- Simultaneous accept and wq2_rptr change in the same cycle: both enter the next-state compare, so the flags reflect both.
- Reset mid-operation: all state clears immediately and asynchronously; in-flight request handshakes are abandoned. Requesters re-present their request after reset.
- NUM_REQ=1 degenerates to a pass-through with full gating; grant_id is 0.

Test Plan:
- Reset check: hold w_rstn=0 with random inputs -> wptr=0, w_full=0, w_afull=0, w_count=0, req_ready=0 when all valid=0. After release with only req_valid[2]=1: grant_id=2, w_addr=0.
- Fill: req 0 continuous, wq2_rptr=0, DEPTH=16 -> accepts on 16 consecutive edges; wptr Gray sequence 0,1,3,2,6,...; w_afull=1 after the 14th accept; w_full=1 after the 16th; req_ready[0]=0 from then on; w_count=16.
- Round-robin: all 4 valid, not full -> grant_id sequence 0,1,2,3,0,1. Drop req 1 after its first grant -> sequence 0,1,2,3,0,2,3,0.
- Full release: from full, step wq2_rptr Gray 0->1 -> w_full=0 one edge later, w_count=15; next accept refills and w_full=1 again.
- Wrap: interleave writes with wq2_rptr tracking to push 40 accepts -> wptr passes 31->0 (Gray 0b10000 -> 0b00000); w_addr continues 15->0 with no spurious full.
- Mid-burst reset: assert w_rstn after 5 accepts with 2 requesters active -> outputs zero immediately; after release, requester 0 is granted first and w_addr=0.

Source files
------------

// File: rtl/fifo_wr_arb_ctrl.sv
// Write-domain controller for the dual-clock FIFO.
// Round-robin arbitrates NUM_REQ requesters onto the single RAM write port,
// owns the binary/Gray write pointer, and derives full / almost-full / fill
// count from the read pointer already synchronized into w_clk (Gray coded).
//
// Ports:
//   w_clk, w_rstn      write clock, asynchronous active-low reset
//   req_valid/req_data per-requester request and packed data
//   req_ready          one-hot accept (combinational)
//   wq2_rptr           synchronized Gray read pointer
//   w_en/w_addr/w_data RAM write port (combinational, same-edge write)
//   wptr               registered Gray write pointer toward the read domain
//   w_full/w_afull     registered full / almost-full flags
//   w_count            registered (pessimistic) fill level
//   grant_id           index of the granted requester, valid while w_en=1
//                      (kept 1 bit wide when NUM_REQ=1, and then always 0)
module fifo_wr_arb_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned AFULL_THRESH = 2,
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          w_clk,
  input  logic                          w_rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [ADDR_WIDTH:0]           wq2_rptr,
  output logic                          w_en,
  output logic [ADDR_WIDTH-1:0]         w_addr,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [ADDR_WIDTH:0]           wptr,
  output logic                          w_full,
  output logic                          w_afull,
  output logic [ADDR_WIDTH:0]           w_count,
  output logic [IDW-1:0]                grant_id
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned SW    = IDW + 2;

  logic [PW-1:0]  r_wbin;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_count;
  logic           r_full;
  logic           r_afull;
  logic [IDW-1:0] r_last_grant;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SW-1:0]        w_start;
  logic [SW-1:0]        w_off;
  logic [SW-1:0]        w_sum;
  logic [SW-1:0]        w_idx;
  logic [IDW-1:0]       w_gidx;
  logic                 w_any;

  // Round-robin search: rotate the request vector so last_grant+1 lands at
  // bit 0, take the lowest set bit, then map the offset back modulo NUM_REQ.
  always_comb begin
    w_start = SW'(r_last_grant) + SW'(1);
    w_dbl   = {req_valid, req_valid};
    w_rot   = NUM_REQ'(w_dbl >> w_start);
    w_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SW'(i);
    end
    w_sum   = w_start + w_off;
    w_idx   = (w_sum >= SW'(NUM_REQ)) ? (w_sum - SW'(NUM_REQ)) : w_sum;
    w_gidx  = IDW'(w_idx);
    w_any   = (|req_valid) & ~r_full;
  end

  // One-hot ready and data mux from the granted index.
  always_comb begin
    req_ready = '0;
    w_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == IDW'(i)) begin
        w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        if (w_any) req_ready[i] = 1'b1;
      end
    end
  end

  assign w_en     = |(req_valid & req_ready);
  assign grant_id = w_gidx;
  assign w_addr   = r_wbin[ADDR_WIDTH-1:0];

  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_diff;
  logic          w_full_next;
  logic          w_afull_next;

  // Next pointer state and flag evaluation against the synchronized read pointer.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_rbin[i] = ^(wq2_rptr >> i);
    end
    w_wbin_next  = r_wbin + PW'(w_en);
    w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
    w_diff       = w_wbin_next - w_rbin;
    // Full when the write Gray pointer equals the read one with its two MSBs inverted.
    w_full_next  = (w_wgray_next == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});
    w_afull_next = (w_diff >= PW'(DEPTH - AFULL_THRESH));
  end

  // Pointer, flag and arbitration-history registers.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_wbin       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_afull      <= 1'b0;
      r_last_grant <= IDW'(NUM_REQ - 1);
    end else begin
      r_wbin  <= w_wbin_next;
      r_wptr  <= w_wgray_next;
      r_count <= w_diff;
      r_full  <= w_full_next;
      r_afull <= w_afull_next;
      if (w_en) r_last_grant <= w_gidx;
    end
  end

  assign wptr    = r_wptr;
  assign w_full  = r_full;
  assign w_afull = r_afull;
  assign w_count = r_count;

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Self-checking bench for fifo_wr_arb_ctrl (default parameters).
// Expected per-cycle outputs come from a behavioural model, are queued when
// the stimulus is applied and compared when the DUT outputs settle.
module tb_fifo_wr_arb_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int THR   = 2;

  logic            w_clk = 1'b0;
  logic            w_rstn;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [PW-1:0]   wq2_rptr;
  logic            w_en;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [PW-1:0]   wptr;
  logic            w_full;
  logic            w_afull;
  logic [PW-1:0]   w_count;
  logic [1:0]      grant_id;

  fifo_wr_arb_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .AFULL_THRESH(THR)
  ) dut (
    .w_clk(w_clk), .w_rstn(w_rstn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .wq2_rptr(wq2_rptr),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .wptr(wptr), .w_full(w_full), .w_afull(w_afull), .w_count(w_count),
    .grant_id(grant_id)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [NR-1:0] rdy;
    logic          en;
    logic [1:0]    gid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [PW-1:0] wptr;
    logic          full;
    logic          afull;
    logic [PW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // model state
  int   m_wbin, m_rbin, m_last, m_cnt, m_acc, m_gid;
  logic m_full, m_afull;
  logic [1:0] obs_gid;

  int rr1[6] = '{0, 1, 2, 3, 0, 1};
  int rr2[8] = '{0, 1, 2, 3, 0, 2, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic model_reset();
    m_wbin = 0; m_rbin = 0; m_last = NR - 1;
    m_full = 1'b0; m_afull = 1'b0; m_cnt = 0;
  endtask

  // One clock: drive, queue expectation, compare at negedge, advance model.
  task automatic cyc();
    exp_t e;
    int   g;
    int   idx;
    int   nb;
    int   diff;
    g = -1;
    wq2_rptr = gray(m_rbin);
    if (!m_full) begin
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    e.rdy   = (g >= 0) ? NR'(1 << g) : '0;
    e.en    = (g >= 0);
    e.gid   = (g >= 0) ? 2'(g) : 2'd0;
    e.data  = (g >= 0) ? req_data[g*DW +: DW] : '0;
    e.addr  = AW'(m_wbin);
    e.wptr  = gray(m_wbin);
    e.full  = m_full;
    e.afull = m_afull;
    e.cnt   = PW'(m_cnt);
    sb_q.push_back(e);

    @(negedge w_clk);
    e = sb_q.pop_front();
    chk("req_ready", 32'(req_ready), 32'(e.rdy));
    chk("w_en", 32'(w_en), 32'(e.en));
    if (e.en) begin
      chk("grant_id", 32'(grant_id), 32'(e.gid));
      chk("w_data", 32'(w_data), 32'(e.data));
    end
    chk("w_addr", 32'(w_addr), 32'(e.addr));
    chk("wptr", 32'(wptr), 32'(e.wptr));
    chk("w_full", 32'(w_full), 32'(e.full));
    chk("w_afull", 32'(w_afull), 32'(e.afull));
    chk("w_count", 32'(w_count), 32'(e.cnt));
    obs_gid = grant_id;
    m_acc = e.en ? 1 : 0;
    m_gid = g;

    @(posedge w_clk);
    if (w_rstn) begin
      nb      = (m_wbin + m_acc) & 31;
      diff    = (nb - m_rbin) & 31;
      m_full  = (diff == DEPTH);
      m_afull = (diff >= DEPTH - THR);
      m_cnt   = diff;
      m_wbin  = nb;
      if (m_acc != 0) m_last = g;
    end
    #1;
    if (m_acc != 0 && w_rstn) req_data[m_gid*DW +: DW] = DW'($urandom);
  endtask

  // Asynchronous reset in the middle of a cycle; registered outputs clear at once.
  task automatic reset_now();
    w_rstn = 1'b0;
    #1;
    chk("rst_wptr", 32'(wptr), 32'd0);
    chk("rst_full", 32'(w_full), 32'd0);
    chk("rst_afull", 32'(w_afull), 32'd0);
    chk("rst_count", 32'(w_count), 32'd0);
    chk("rst_addr", 32'(w_addr), 32'd0);
    model_reset();
  endtask

  initial begin
    int nacc;
    int prev;
    w_rstn    = 1'b1;
    req_valid = '0;
    req_data  = {$urandom, $urandom} ;
    wq2_rptr  = '0;
    model_reset();
    #2;
    reset_now();

    // reset held with random inputs
    repeat (3) begin
      req_valid = NR'($urandom);
      m_rbin    = $urandom & 31;
      cyc();
    end
    req_valid = '0;
    m_rbin    = 0;
    cyc();
    w_rstn    = 1'b1;
    req_valid = 4'b0100;
    cyc();
    chk("first_gid", 32'(obs_gid), 32'd2);
    req_valid = '0;
    cyc();

    // fill to full with requester 0
    reset_now();
    w_rstn    = 1'b1;
    req_valid = 4'b0001;
    repeat (18) cyc();
    chk("fill_count", 32'(w_count), 32'd16);
    chk("fill_full", 32'(w_full), 32'd1);

    // one read slot frees, then refills
    m_rbin = 1;
    repeat (3) cyc();
    chk("refill_full", 32'(w_full), 32'd1);

    // round-robin with all requesters active
    reset_now();
    w_rstn    = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_seq", 32'(obs_gid), 32'(rr1[i]));
    end

    // round-robin with requester 1 dropping after its first grant
    reset_now();
    w_rstn    = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_drop_seq", 32'(obs_gid), 32'(rr2[i]));
      if (m_acc != 0 && m_gid == 1) req_valid[1] = 1'b0;
    end

    // pointer wrap with a trailing read pointer
    reset_now();
    w_rstn    = 1'b1;
    req_valid = 4'b0011;
    nacc      = 0;
    repeat (45) begin
      prev = m_wbin;
      cyc();
      nacc += m_acc;
      m_rbin = prev;
    end
    chk("wrap_accepts", 32'(nacc >= 40), 32'd1);

    // reset in the middle of a burst
    reset_now();
    w_rstn    = 1'b1;
    req_valid = 4'b0011;
    repeat (5) cyc();
    chk("burst_addr", 32'(w_addr), 32'd5);
    reset_now();
    cyc();
    w_rstn = 1'b1;
    cyc();
    chk("post_rst_gid", 32'(obs_gid), 32'd0);

    // random traffic with a lagging read pointer
    reset_now();
    w_rstn = 1'b1;
    repeat (200) begin
      req_valid = NR'($urandom);
      if ($urandom_range(0, 2) == 0)
        m_rbin = (m_rbin + $urandom_range(0, (m_wbin - m_rbin) & 31)) & 31;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
